peach_fetch: RTL and testbench
==============================

Name: peach_fetch

Overview:
- Boot-and-fetch front end of the Peach multicycle RV32I core; sits directly upstream of the opcode-class decoder.
- After reset, copies the boot ROM into instruction memory. It then repeatedly reads imem[pc] into the instruction register and presents it with a valid/ready handshake to decode/control.
- Owns the PC. Advances it by 4 per accepted instruction, or loads a redirect target from branch/jump logic.

Parameters:
- ROM_WORDS, 256, number of 32-bit words copied from ROM to imem at boot (>=1).
- ADDR_W, 8, word-address width of ROM and imem (2**ADDR_W >= ROM_WORDS).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  ADDR_W  boot ROM word address.
- rom_data  in  32  ROM read data, valid one cycle after rom_addr (synchronous ROM).
- imem_we  out  1  imem write strobe (boot copy only).
- imem_waddr  out  ADDR_W  imem write word address.
- imem_wdata  out  32  imem write data.
- imem_raddr  out  ADDR_W  imem read word address.
- imem_rdata  in  32  imem read data, valid one cycle after imem_raddr.
- boot_done  out  1  high once copy complete; stays high until reset.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr_ready  in  1  consumer accepts instruction when high with instr_valid.
- instr  out  32  fetched instruction word.
- instr_pc  out  32  byte address of instr.
- redirect_valid  in  1  load PC with redirect_pc (branch/jump taken).
- redirect_pc  in  32  byte-address redirect target.
- fetch_fault  out  1  misaligned redirect flag (see Optional Feature; tied 0 otherwise).

Behaviour:
- Reset (async, any state, including mid-boot or mid-fetch):
  - state=BOOT, pc=0, copy counter=0.
  - boot_done=0, instr_valid=0, instr=0, instr_pc=0, imem_we=0, fetch_fault=0.
  - All address outputs reset to 0.
- BOOT:
  - rom_addr = counter; counter increments each cycle until it reaches ROM_WORDS-1, then holds.
  - Cycle after address k is issued: imem_we=1, imem_waddr=k, imem_wdata=rom_data.
  - After the write of word ROM_WORDS-1: boot_done=1, pc=0, state=FETCH.
  - Copy takes ROM_WORDS+1 cycles. imem_we is never high outside BOOT.
  - redirect_valid and instr_ready are ignored in BOOT.
- FETCH:
  - imem_raddr = pc[ADDR_W+1:2]; next state WAIT.
- WAIT:
  - Capture instr=imem_rdata and instr_pc=pc; next state VALID.
  - instr_valid rises on the following cycle, i.e. 2 cycles after entering FETCH.
- VALID:
  - instr_valid=1; instr and instr_pc are held stable while instr_ready=0.
  - On instr_ready=1: instr_valid=0 next cycle, pc=pc+4, state=FETCH.
- Redirect:
  - redirect_valid=1 in FETCH, WAIT or VALID: pc=redirect_pc, state=FETCH, instr_valid=0 next cycle.
  - Any in-flight read is discarded.
  - Redirect together with instr_ready in VALID: the redirect wins (the instruction counts as accepted, pc = target, not pc+4).
- Arithmetic and wrap:
  - pc+4 is a 32-bit modulo add, so 0xFFFFFFFC wraps to 0.
  - imem_raddr truncates pc, so addresses beyond the imem depth alias.
- Misaligned redirect (macro absent): redirect_pc[1:0] is cleared before loading pc.

Optional Feature:
- Macro PEACH_FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets fetch_fault=1, loads pc unmodified, enters state FAULT.
  - FAULT: no fetch issued, instr_valid=0.
  - fetch_fault stays high until an aligned redirect (returns to FETCH, clears fault) or reset.
  - A misaligned redirect while in FAULT keeps the fault.
- Undefined:
  - Low two bits of redirect_pc are cleared; no FAULT state exists; fetch_fault is tied 0.

Test Plan:
- ROM_WORDS=4, ROM={0x00000013, 0x00100093, 0x00208133, 0x0000006F}, release rst_n -> four imem writes at addresses 0..3 with those data; boot_done high 5 cycles after release; first instr=0x00000013, instr_pc=0, instr_valid 2 cycles after boot_done.
- instr_ready held 0 for 10 cycles on instr 0x00100093 -> instr and instr_pc=4 stable; no new imem_raddr activity; on ready, next instr_pc=8.
- redirect_valid with redirect_pc=0x0000000C asserted in WAIT while fetching pc=4 -> pc=4 read discarded; next valid instr=0x0000006F, instr_pc=0xC.
- redirect_valid (pc=0) and instr_ready asserted together in VALID at instr_pc=8 -> next instr_pc=0, not 0xC.
- Reset asserted mid-boot at copy word 2 -> boot_done=0 and instr_valid=0 immediately; after release, copy restarts from rom_addr=0 with full ROM_WORDS+1 cycle duration.
- With PEACH_FETCH_MISALIGN_TRAP_EN, redirect_pc=0x6 -> fetch_fault=1, instr_valid stays 0; then redirect_pc=0x4 -> fault clears, instr=0x00100093. Without the macro, redirect_pc=0x6 -> instr_pc=0x4.

Source files
------------

// File: rtl/peach_fetch.sv
// peach_fetch: boot-and-fetch front end of the Peach multicycle RV32I core.
//
// After reset the boot ROM is copied word by word into instruction memory.
// The block then loops FETCH -> WAIT -> VALID, presenting each fetched word
// on a valid/ready handshake. The PC advances by 4 per accepted instruction
// or is loaded from a branch/jump redirect.
//
// Build option:
//   PEACH_FETCH_MISALIGN_TRAP_EN  - a redirect with redirect_pc[1:0] != 0
//     enters a FAULT state and raises fetch_fault until an aligned redirect
//     arrives. Without it, the low two bits of the target are cleared and
//     fetch_fault is tied low.
module peach_fetch #(
    parameter int ROM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W-1:0] imem_raddr,
    input  logic [31:0]       imem_rdata,
    output logic              boot_done,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [31:0]       instr_pc,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              fetch_fault
);

    // Index of the final ROM word; the copy ends once this word is written.
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(ROM_WORDS - 1);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_WAIT,
        S_VALID
`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
        , S_FAULT
`endif
    } state_t;

    state_t            state, state_n;
    logic [31:0]       pc, pc_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] waddr_q, waddr_n;
    logic              boot_done_q, boot_done_n;
    logic [31:0]       instr_q, instr_n;
    logic [31:0]       instr_pc_q, instr_pc_n;
    logic              redirect_take;
    logic [31:0]       redirect_aligned;

`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
    logic              fault_q, fault_n;
    logic              redirect_misaligned;
    assign redirect_misaligned = redirect_pc[1:0] != 2'b00;
`endif

    // Redirects only matter once the copy is finished; BOOT ignores them.
    assign redirect_take    = redirect_valid && (state != S_BOOT);
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    // State register and all datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= '0;
            cnt         <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            boot_done_q <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            cnt         <= cnt_n;
            we_q        <= we_n;
            waddr_q     <= waddr_n;
            boot_done_q <= boot_done_n;
            instr_q     <= instr_n;
            instr_pc_q  <= instr_pc_n;
        end
    end

`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
    // Sticky misalignment flag, cleared only by an aligned redirect or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_n;
        end
    end
`endif

    // Next-state and next-datapath logic for boot copy and fetch loop.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path
        // through the case statement can leave one unassigned (no latches).
        state_n     = state;
        pc_n        = pc;
        cnt_n       = cnt;
        we_n        = 1'b0;
        waddr_n     = waddr_q;
        boot_done_n = boot_done_q;
        instr_n     = instr_q;
        instr_pc_n  = instr_pc_q;
`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
        fault_n     = fault_q;
`endif

        case (state)
            S_BOOT: begin
                // Issue ROM address cnt now; its data is written next cycle.
                if (cnt != LAST_WORD) begin
                    cnt_n = cnt + 1'b1;
                end
                we_n    = 1'b1;
                waddr_n = cnt;
                // Final word is being written this cycle: leave BOOT.
                if (we_q && (waddr_q == LAST_WORD)) begin
                    we_n        = 1'b0;
                    boot_done_n = 1'b1;
                    pc_n        = '0;
                    state_n     = S_FETCH;
                end
            end
            S_FETCH: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // Read data for pc is on imem_rdata now.
                instr_n    = imem_rdata;
                instr_pc_n = pc;
                state_n    = S_VALID;
            end
            S_VALID: begin
                if (instr_ready) begin
                    pc_n    = pc + 32'd4;
                    state_n = S_FETCH;
                end
            end
`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
            S_FAULT: begin
                // Parked: nothing is fetched until a redirect arrives.
                state_n = S_FAULT;
            end
`endif
            default: begin
                state_n = S_BOOT;
            end
        endcase

        // A redirect overrides the fetch loop in every non-boot state; an
        // in-flight read is dropped and the held instruction is not updated.
        if (redirect_take) begin
            instr_n    = instr_q;
            instr_pc_n = instr_pc_q;
`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
            pc_n = redirect_pc;
            if (redirect_misaligned) begin
                fault_n = 1'b1;
                state_n = S_FAULT;
            end else begin
                fault_n = 1'b0;
                state_n = S_FETCH;
            end
`else
            pc_n    = redirect_aligned;
            state_n = S_FETCH;
`endif
        end
    end

    // Output mapping: addresses come straight from registers.
    assign rom_addr    = cnt;
    assign imem_we     = we_q;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = rom_data;
    assign imem_raddr  = pc[ADDR_W+1:2];
    assign boot_done   = boot_done_q;
    assign instr_valid = (state == S_VALID);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_peach_fetch.sv
// tb_peach_fetch: directed + randomized check of peach_fetch with a 4-word
// boot ROM. ROM and imem are modelled as synchronous memories; expected
// instructions are derived from the ROM image and the imem prefill.
module tb_peach_fetch;

    localparam int ROM_WORDS = 4;
    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 256;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W-1:0] imem_raddr;
    logic [31:0]       imem_rdata;
    logic              boot_done;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic              fetch_fault;

    peach_fetch #(.ROM_WORDS(ROM_WORDS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
        .boot_done(boot_done),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory images: rom_img is the boot ROM, pre is imem content before boot.
    logic [31:0] rom_img [DEPTH];
    logic [31:0] pre     [DEPTH];
    logic [31:0] imem    [DEPTH];
    bit          written [DEPTH];

    // Synchronous ROM and imem with one-cycle read latency.
    always @(posedge clk) begin
        rom_data   <= rom_img[rom_addr];
        imem_rdata <= written[imem_raddr] ? imem[imem_raddr] : pre[imem_raddr];
        if (imem_we) begin
            imem[imem_waddr]    <= imem_wdata;
            written[imem_waddr] <= 1'b1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word the core should see at byte address a: ROM image for the copied
    // words, the prefill elsewhere (addresses alias modulo imem depth).
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        int w;
        w = int'((a >> 2) % DEPTH);
        return (w < ROM_WORDS) ? rom_img[w] : pre[w];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int bound);
        int n;
        n = 0;
        while (!instr_valid && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(instr_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] target;
        logic        was_valid;
        int          idle;
        int          n;

        for (int i = 0; i < DEPTH; i++) begin
            rom_img[i] = '0;
            pre[i]     = $urandom;
        end
        rom_img[0] = 32'h0000_0013;
        rom_img[1] = 32'h0010_0093;
        rom_img[2] = 32'h0020_8133;
        rom_img[3] = 32'h0000_006F;

        // Reset state.
        repeat (3) tick();
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_raddr", 32'(imem_raddr), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);

        // Boot copy; redirect and ready held high must be ignored.
        rst_n          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        instr_ready    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k <= 4) begin
                check($sformatf("boot_we%0d", k), 32'(imem_we), 32'd1);
                check($sformatf("boot_waddr%0d", k), 32'(imem_waddr), 32'(k - 1));
                check($sformatf("boot_wdata%0d", k), imem_wdata, rom_img[k - 1]);
                check($sformatf("boot_rom_addr%0d", k), 32'(rom_addr), 32'((k < 3) ? k : 3));
            end else begin
                check("boot_we_end", 32'(imem_we), 32'd0);
            end
            check($sformatf("boot_done%0d", k), 32'(boot_done), 32'(k == 5));
        end
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;

        // First instruction appears two cycles after boot_done.
        tick();
        check("first_valid_early", 32'(instr_valid), 32'd0);
        tick();
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_instr", instr, 32'h0000_0013);
        check("first_pc", instr_pc, 32'd0);

        // Accept, then hold the next instruction with ready low.
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("accept_drop", 32'(instr_valid), 32'd0);
        wait_valid("pc4", 8);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", instr, 32'h0010_0093);
            check("hold_pc", instr_pc, 32'd4);
            check("hold_raddr", 32'(imem_raddr), 32'd1);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_valid("pc8", 8);
        check("pc8_pc", instr_pc, 32'd8);
        check("pc8_instr", instr, 32'h0020_8133);

        // Redirect together with ready: redirect wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        check("rdy_redir_drop", 32'(instr_valid), 32'd0);
        wait_valid("rdy_redir", 8);
        check("rdy_redir_pc", instr_pc, 32'd0);
        check("rdy_redir_instr", instr, 32'h0000_0013);

        // Redirect during WAIT of the pc=4 fetch.
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        check("wait_raddr", 32'(imem_raddr), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        tick();
        redirect_valid = 1'b0;
        check("wait_redir_drop", 32'(instr_valid), 32'd0);
        wait_valid("wait_redir", 8);
        check("wait_redir_pc", instr_pc, 32'hC);
        check("wait_redir_instr", instr, 32'h0000_006F);

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            check("fault_flag", 32'(fetch_fault), 32'd1);
            check("fault_valid", 32'(instr_valid), 32'd0);
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4;
        tick();
        redirect_valid = 1'b0;
        check("fault_clear", 32'(fetch_fault), 32'd0);
`else
        check("misalign_fault", 32'(fetch_fault), 32'd0);
`endif
        wait_valid("misalign", 8);
        check("misalign_pc", instr_pc, 32'h4);
        check("misalign_instr", instr, 32'h0010_0093);

        // PC wrap: 0xFFFFFFFC + 4 = 0.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_valid("top", 8);
        check("top_pc", instr_pc, 32'hFFFF_FFFC);
        check("top_instr", instr, exp_word(32'hFFFF_FFFC));
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_valid("wrap", 8);
        check("wrap_pc", instr_pc, 32'd0);
        check("wrap_instr", instr, 32'h0000_0013);

        // Randomized handshake/redirect traffic against a transaction model.
        exp_pc = 32'd0;
        idle   = 0;
        for (int i = 0; i < 400; i++) begin
            was_valid      = instr_valid;
            instr_ready    = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 7) == 0);
            target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h3FF);
`ifdef PEACH_FETCH_MISALIGN_TRAP_EN
            target = target & 32'hFFFF_FFFC;
`endif
            redirect_pc = target;
            if (redirect_valid) begin
                exp_pc = target & 32'hFFFF_FFFC;
                idle   = 0;
            end else if (was_valid && instr_ready) begin
                exp_pc = exp_pc + 32'd4;
            end
            tick();
            if (instr_valid) begin
                check("rand_pc", instr_pc, exp_pc);
                check("rand_instr", instr, exp_word(exp_pc));
                idle = 0;
            end else begin
                idle++;
                check("rand_idle", 32'(idle <= 2), 32'd1);
            end
            check("rand_fault", 32'(fetch_fault), 32'd0);
        end
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;

        // Asynchronous reset while an instruction is valid.
        wait_valid("pre_reset", 8);
        rst_n = 1'b0;
        #1;
        check("midfetch_valid", 32'(instr_valid), 32'd0);
        check("midfetch_boot_done", 32'(boot_done), 32'd0);
        check("midfetch_instr", instr, 32'd0);
        check("midfetch_pc", instr_pc, 32'd0);

        // Reset in the middle of the boot copy, then a full restart.
        rst_n = 1'b1;
        tick();
        tick();
        check("midboot_rom_addr", 32'(rom_addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check("midboot_boot_done", 32'(boot_done), 32'd0);
        check("midboot_valid", 32'(instr_valid), 32'd0);
        check("midboot_we", 32'(imem_we), 32'd0);
        check("midboot_rom_addr0", 32'(rom_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        n = 0;
        while (!boot_done && n < 20) begin
            tick();
            n++;
        end
        check("reboot_cycles", 32'(n), 32'd5);
        wait_valid("reboot", 8);
        check("reboot_pc", instr_pc, 32'd0);
        check("reboot_instr", instr, 32'h0000_0013);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
